// File: rtl/div3_pkg.sv
// Shared types and the bit-serial mod-3 step for the div3 stream scheduler.
package div3_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StShift,
    StResp
  } state_e;

  typedef logic [1:0] residue_t;

  // Horner step: r' = (2r + b) mod 3; residue 3 never occurs and maps to 0.
  function automatic residue_t mod3_step(input residue_t r, input logic b);
    residue_t res;
    unique case ({r, b})
      3'b000:  res = 2'd0;
      3'b001:  res = 2'd1;
      3'b010:  res = 2'd2;
      3'b011:  res = 2'd0;
      3'b100:  res = 2'd1;
      3'b101:  res = 2'd2;
      default: res = 2'd0;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/mod3_residue_tracker.sv
// Two-bit running residue of an MSB-first bit stream; clr has priority over en.
module mod3_residue_tracker
  import div3_pkg::*;
(
  input  logic     clk,
  input  logic     rst_n,
  input  logic     clr,
  input  logic     en,
  input  logic     bit_in,
  output residue_t residue
);

  residue_t residue_q, residue_d;

  always_comb begin
    residue_d = residue_q;
    if (clr) begin
      residue_d = 2'd0;
    end else if (en) begin
      residue_d = mod3_step(residue_q, bit_in);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      residue_q <= 2'd0;
    end else begin
      residue_q <= residue_d;
    end
  end

  assign residue = residue_q;

endmodule

// File: rtl/div3_stream_scheduler.sv
// Round-robin front end sharing one serial mod-3 engine among NUM_REQ requesters.
// Optional DIV3_STAT_CNT_EN adds saturating response/hit counters.
module div3_stream_scheduler
  import div3_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned DATA_W  = 16,
  parameter int unsigned ID_W    = $clog2(NUM_REQ),
  parameter int unsigned CNT_W   = $clog2(DATA_W + 1)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [ID_W-1:0]           rsp_id,
  output logic [1:0]                rsp_residue,
  output logic                      rsp_div3,
  output logic                      busy
`ifdef DIV3_STAT_CNT_EN
  ,
  output logic [15:0]               stat_words,
  output logic [15:0]               stat_hits
`endif
);

  state_e            state_q, state_d;
  logic [ID_W-1:0]   ptr_q, ptr_d;
  logic [ID_W-1:0]   id_q, id_d;
  logic [DATA_W-1:0] shreg_q, shreg_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  residue_t          res_q, res_d;
  logic              div3_q, div3_d;

  logic              found;
  logic [ID_W-1:0]   win;
  int unsigned       idx;
  logic              accept;
  residue_t          trk_residue;
  residue_t          final_res;

  // First valid requester searching upward from ptr with wrap.
  always_comb begin
    found = 1'b0;
    win   = '0;
    idx   = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = (int'(ptr_q) + k) % NUM_REQ;
      if (!found && req_valid[idx[ID_W-1:0]]) begin
        found = 1'b1;
        win   = idx[ID_W-1:0];
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (rst_n && state_q == StIdle && found) begin
      req_ready[win] = 1'b1;
    end
  end

  assign accept    = (state_q == StIdle) && found;
  assign final_res = mod3_step(trk_residue, shreg_q[DATA_W-1]);

  mod3_residue_tracker u_tracker (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (accept),
    .en      (state_q == StShift),
    .bit_in  (shreg_q[DATA_W-1]),
    .residue (trk_residue)
  );

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    id_d    = id_q;
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    res_d   = res_q;
    div3_d  = div3_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          state_d = StShift;
          shreg_d = req_data[win*DATA_W +: DATA_W];
          id_d    = win;
          cnt_d   = CNT_W'(DATA_W);
          ptr_d   = (win == ID_W'(NUM_REQ - 1)) ? '0 : win + 1'b1;
        end
      end
      StShift: begin
        shreg_d = shreg_q << 1;
        cnt_d   = cnt_q - CNT_W'(1);
        // Capture the result on the last bit so the response fields are registered.
        if (cnt_q == CNT_W'(1)) begin
          state_d = StResp;
          res_d   = final_res;
          div3_d  = (final_res == 2'd0);
        end
      end
      StResp: begin
        if (rsp_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      ptr_q   <= '0;
      id_q    <= '0;
      shreg_q <= '0;
      cnt_q   <= '0;
      res_q   <= 2'd0;
      div3_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      id_q    <= id_d;
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
      res_q   <= res_d;
      div3_q  <= div3_d;
    end
  end

  assign rsp_valid   = (state_q == StResp);
  assign rsp_id      = id_q;
  assign rsp_residue = res_q;
  assign rsp_div3    = div3_q;
  assign busy        = (state_q != StIdle);

`ifdef DIV3_STAT_CNT_EN
  logic [15:0] words_q, words_d;
  logic [15:0] hits_q, hits_d;

  always_comb begin
    words_d = words_q;
    hits_d  = hits_q;
    if (rsp_valid && rsp_ready) begin
      if (words_q != 16'hFFFF) words_d = words_q + 16'd1;
      if (div3_q && hits_q != 16'hFFFF) hits_d = hits_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      words_q <= '0;
      hits_q  <= '0;
    end else begin
      words_q <= words_d;
      hits_q  <= hits_d;
    end
  end

  assign stat_words = words_q;
  assign stat_hits  = hits_q;
`endif

endmodule
